// File: rtl/score_pkg.sv
//------------------------------------------------------------------------------
// score_pkg : point values, points lookup and drain FSM encoding shared by
//             score_event_arbiter.
// Rev 1.0   : initial release
//------------------------------------------------------------------------------
`default_nettype none

package score_pkg;

    localparam int PTS_W       = 4;
    localparam int PTS_1_LINE  = 1;
    localparam int PTS_2_LINE  = 3;
    localparam int PTS_3_LINE  = 5;
    localparam int PTS_4_LINE  = 8;
    localparam int DROP_POINTS = 1;

    localparam logic [0:0] ST_READY = 1'b0;
    localparam logic [0:0] ST_GAP   = 1'b1;

    // Out-of-range line counts are still granted, but they earn nothing.
    function automatic logic [PTS_W-1:0] line_points(input logic [2:0] cnt);
        case (cnt)
            3'd1:    line_points = PTS_W'(PTS_1_LINE);
            3'd2:    line_points = PTS_W'(PTS_2_LINE);
            3'd3:    line_points = PTS_W'(PTS_3_LINE);
            3'd4:    line_points = PTS_W'(PTS_4_LINE);
            default: line_points = '0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/score_event_arbiter.sv
//------------------------------------------------------------------------------
// score_event_arbiter : arbitrates line-clear and hard-drop point events into
//                       a pending accumulator drained as spaced score pulses.
//                       Optional drop requester enabled by SCORE_DROP_EN.
// Rev 1.0             : initial release
//------------------------------------------------------------------------------
`default_nettype none

module score_event_arbiter
    import score_pkg::*;
#(
    parameter int PULSE_GAP = 3,
    parameter int PEND_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_req,
    input  logic [2:0]        line_cnt,
    output logic              line_ack,
    input  logic              drop_req,
    output logic              drop_ack,
    input  logic              game_over,
    output logic              score_plus,
    output logic [PEND_W-1:0] pending,
    output logic              busy
);

    localparam logic [PEND_W:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};

    logic [0:0]        state_q, state_d;
    logic [2:0]        gap_q, gap_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              score_plus_q, score_plus_d;

    logic [PTS_W-1:0]  w_line_pts;
    logic [PEND_W:0]   w_line_sum;
    logic              w_line_ack;
    logic              w_drop_ack;
    logic              w_drain;
    logic [PEND_W:0]   w_add;

    // Headroom is judged on the registered count; a same-cycle drain is not credited.
    assign w_line_pts = line_points(line_cnt);
    assign w_line_sum = {1'b0, pending_q} + (PEND_W+1)'(w_line_pts);
    assign w_line_ack = !reset && !game_over && line_req && (w_line_sum <= PEND_MAX);

`ifdef SCORE_DROP_EN
    logic [PEND_W:0] w_drop_sum;
    assign w_drop_sum = {1'b0, pending_q} + (PEND_W+1)'(DROP_POINTS);
    assign w_drop_ack = !reset && !game_over && drop_req && !w_line_ack
                        && (w_drop_sum <= PEND_MAX);
`else
    logic w_unused_drop;
    assign w_unused_drop = drop_req;
    assign w_drop_ack    = 1'b0;
`endif

    assign w_drain = (state_q == ST_READY) && (pending_q != '0);

    always_comb begin
        w_add = '0;
        if (w_line_ack) begin
            w_add = (PEND_W+1)'(w_line_pts);
        end else if (w_drop_ack) begin
            w_add = (PEND_W+1)'(DROP_POINTS);
        end
    end

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        score_plus_d = 1'b0;
        pending_d    = PEND_W'({1'b0, pending_q} + w_add - (PEND_W+1)'(w_drain));
        case (state_q)
            ST_READY: begin
                if (w_drain) begin
                    score_plus_d = 1'b1;
                    if (PULSE_GAP > 0) begin
                        gap_d   = 3'(PULSE_GAP);
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q - 3'd1;
                if (gap_q <= 3'd1) begin
                    gap_d   = 3'd0;
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_READY;
                gap_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_READY;
            gap_q        <= 3'd0;
            pending_q    <= '0;
            score_plus_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            pending_q    <= pending_d;
            score_plus_q <= score_plus_d;
        end
    end

    assign line_ack   = w_line_ack;
    assign drop_ack   = w_drop_ack;
    assign score_plus = score_plus_q;
    assign pending    = pending_q;
    assign busy       = !reset && ((pending_q != '0) || (gap_q != 3'd0));

endmodule

`default_nettype wire

// File: tb/tb_score_event_arbiter.sv
//------------------------------------------------------------------------------
// tb_score_event_arbiter : directed self-checking bench for score_event_arbiter
//                          (default PULSE_GAP=3, PEND_W=6).
// Rev 1.0                : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_score_event_arbiter;

    logic       clk;
    logic       reset;
    logic       line_req;
    logic [2:0] line_cnt;
    logic       line_ack;
    logic       drop_req;
    logic       drop_ack;
    logic       game_over;
    logic       score_plus;
    logic [5:0] pending;
    logic       busy;

    int checks = 0;
    int errors = 0;

    score_event_arbiter #(.PULSE_GAP(3), .PEND_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .line_req   (line_req),
        .line_cnt   (line_cnt),
        .line_ack   (line_ack),
        .drop_req   (drop_req),
        .drop_ack   (drop_ack),
        .game_over  (game_over),
        .score_plus (score_plus),
        .pending    (pending),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; line_req = 1'b0; line_cnt = 3'd0; drop_req = 1'b0; game_over = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; line_req = 1'b1; line_cnt = 3'd4; drop_req = 1'b1; game_over = 1'b0;
        step();
        checks++; if (pending !== 6'd0)    begin errors++; $display("FAIL reset_pending got %0d exp 0", pending); end
        checks++; if (score_plus !== 1'b0) begin errors++; $display("FAIL reset_score_plus got %b exp 0", score_plus); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (line_ack !== 1'b0)   begin errors++; $display("FAIL reset_line_ack got %b exp 0", line_ack); end
        checks++; if (drop_ack !== 1'b0)   begin errors++; $display("FAIL reset_drop_ack got %b exp 0", drop_ack); end
        line_req = 1'b0; drop_req = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_points();
        logic [2:0] cnts [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd7};
        logic [5:0] exps [6] = '{6'd0, 6'd1, 6'd3, 6'd5, 6'd0, 6'd0};
        for (int i = 0; i < 6; i++) begin
            apply_reset();
            line_cnt = cnts[i]; line_req = 1'b1;
            #1;
            checks++; if (line_ack !== 1'b1) begin errors++; $display("FAIL points_ack cnt=%0d got %b exp 1", cnts[i], line_ack); end
            step();
            line_req = 1'b0;
            checks++; if (pending !== exps[i]) begin errors++; $display("FAIL points_pending cnt=%0d got %0d exp %0d", cnts[i], pending, exps[i]); end
        end
    endtask

    task automatic test_line4();
        int pulses = 0;
        logic exp_sp;
        apply_reset();
        line_cnt = 3'd4; line_req = 1'b1;
        #1;
        checks++; if (line_ack !== 1'b1) begin errors++; $display("FAIL line4_ack got %b exp 1", line_ack); end
        step();
        line_req = 1'b0;
        checks++; if (pending !== 6'd8)    begin errors++; $display("FAIL line4_pending got %0d exp 8", pending); end
        checks++; if (score_plus !== 1'b0) begin errors++; $display("FAIL line4_first_sp got %b exp 0", score_plus); end
        for (int c = 1; c <= 34; c++) begin
            step();
            exp_sp = (c <= 29) && ((c - 1) % 4 == 0);
            if (score_plus === 1'b1) pulses++;
            checks++; if (score_plus !== exp_sp) begin errors++; $display("FAIL line4_sp cycle=%0d got %b exp %b", c, score_plus, exp_sp); end
            checks++; if (busy !== (c < 32)) begin errors++; $display("FAIL line4_busy cycle=%0d got %b exp %b", c, busy, (c < 32)); end
        end
        checks++; if (pulses != 8) begin errors++; $display("FAIL line4_pulses got %0d exp 8", pulses); end
    endtask

    task automatic test_overflow();
        int pulses = 0;
        int cyc = 0;
        logic exp_ack;
        apply_reset();
        line_cnt = 3'd4; line_req = 1'b1;
        for (int k = 0; k <= 34; k++) begin
            #1;
            exp_ack = (k <= 7) || (k == 34);
            checks++; if (line_ack !== exp_ack) begin errors++; $display("FAIL ovf_ack k=%0d got %b exp %b", k, line_ack, exp_ack); end
            step();
            if (k == 7)  begin checks++; if (pending !== 6'd62) begin errors++; $display("FAIL ovf_pend62 got %0d exp 62", pending); end end
            if (k == 13) begin checks++; if (pending !== 6'd60) begin errors++; $display("FAIL ovf_pend60 got %0d exp 60", pending); end end
            if (k == 33) begin checks++; if (pending !== 6'd55) begin errors++; $display("FAIL ovf_pend55 got %0d exp 55", pending); end end
            if (k == 34) begin checks++; if (pending !== 6'd63) begin errors++; $display("FAIL ovf_pend63 got %0d exp 63", pending); end end
        end
        line_req = 1'b0;
        while (busy === 1'b1 && cyc < 400) begin
            step();
            cyc++;
            if (score_plus === 1'b1) pulses++;
        end
        checks++; if (cyc >= 400) begin errors++; $display("FAIL ovf_drain_timeout busy=%b exp 0", busy); end
        checks++; if (pulses != 63) begin errors++; $display("FAIL ovf_pulses got %0d exp 63", pulses); end
    endtask

    task automatic test_game_over();
        int pulses = 0;
        apply_reset();
        line_cnt = 3'd3; line_req = 1'b1;
        step();
        checks++; if (pending !== 6'd5) begin errors++; $display("FAIL go_pending got %0d exp 5", pending); end
        game_over = 1'b1; line_cnt = 3'd1; drop_req = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            #1;
            checks++; if (line_ack !== 1'b0) begin errors++; $display("FAIL go_line_ack cycle=%0d got %b exp 0", c, line_ack); end
            checks++; if (drop_ack !== 1'b0) begin errors++; $display("FAIL go_drop_ack cycle=%0d got %b exp 0", c, drop_ack); end
            step();
            if (score_plus === 1'b1) pulses++;
        end
        checks++; if (pulses != 5)   begin errors++; $display("FAIL go_pulses got %0d exp 5", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL go_busy got %b exp 0", busy); end
        game_over = 1'b0; line_req = 1'b0; drop_req = 1'b0;
    endtask

    task automatic test_reset_mid_gap();
        apply_reset();
        line_cnt = 3'd3; line_req = 1'b1;
        step();
        line_req = 1'b0;
        for (int c = 1; c <= 5; c++) step();
        checks++; if (pending !== 6'd3)    begin errors++; $display("FAIL rgap_pre_pending got %0d exp 3", pending); end
        checks++; if (score_plus !== 1'b1) begin errors++; $display("FAIL rgap_pre_sp got %b exp 1", score_plus); end
        reset = 1'b1;
        step();
        checks++; if (pending !== 6'd0)    begin errors++; $display("FAIL rgap_pending got %0d exp 0", pending); end
        checks++; if (score_plus !== 1'b0) begin errors++; $display("FAIL rgap_sp got %b exp 0", score_plus); end
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            checks++; if (score_plus !== 1'b0 || pending !== 6'd0) begin
                errors++; $display("FAIL rgap_after cycle=%0d sp=%b pending=%0d exp 0/0", c, score_plus, pending);
            end
        end
    endtask

`ifdef SCORE_DROP_EN
    task automatic test_drop_priority();
        int pulses = 0;
        apply_reset();
        line_cnt = 3'd2; line_req = 1'b1; drop_req = 1'b1;
        #1;
        checks++; if (line_ack !== 1'b1 || drop_ack !== 1'b0) begin errors++; $display("FAIL prio_first line=%b drop=%b exp 1/0", line_ack, drop_ack); end
        step();
        line_req = 1'b0;
        #1;
        checks++; if (line_ack !== 1'b0 || drop_ack !== 1'b1) begin errors++; $display("FAIL prio_second line=%b drop=%b exp 0/1", line_ack, drop_ack); end
        step();
        drop_req = 1'b0;
        checks++; if (pending !== 6'd3 || score_plus !== 1'b1) begin errors++; $display("FAIL prio_pending got %0d/%b exp 3/1", pending, score_plus); end
        pulses = 1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (score_plus === 1'b1) pulses++;
        end
        checks++; if (pulses != 4)   begin errors++; $display("FAIL prio_pulses got %0d exp 4", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_busy got %b exp 0", busy); end
    endtask
`else
    task automatic test_drop_disabled();
        apply_reset();
        drop_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            #1;
            checks++; if (drop_ack !== 1'b0) begin errors++; $display("FAIL nodrop_ack cycle=%0d got %b exp 0", c, drop_ack); end
            step();
            checks++; if (score_plus !== 1'b0) begin errors++; $display("FAIL nodrop_sp cycle=%0d got %b exp 0", c, score_plus); end
        end
        drop_req = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; line_req = 1'b0; line_cnt = 3'd0; drop_req = 1'b0; game_over = 1'b0;
        test_reset();
        test_points();
        test_line4();
        test_overflow();
        test_game_over();
        test_reset_mid_gap();
`ifdef SCORE_DROP_EN
        test_drop_priority();
`else
        test_drop_disabled();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
